// File: rtl/systolic_mac_pe.sv
// Output-stationary MAC processing element: operand forwarding east/south, wide accumulator,
// and a double-buffered result register that shifts along the column result chain.
module systolic_mac_pe #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic                  in_valid,
  input  logic                  acc_clear,
  input  logic                  drain,
  input  logic [ACC_WIDTH-1:0]  c_in,
  input  logic                  c_in_valid,
  input  logic                  c_shift,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic                  out_valid,
  output logic [ACC_WIDTH-1:0]  c_out,
  output logic                  c_out_valid,
  output logic                  busy,
  output logic                  overflow,
  output logic                  overrun
);

  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  w_acc_nxt;
  logic                  w_ovf_nxt;
  logic                  w_a_sx;
  logic                  w_b_sx;
  logic                  w_p_sx;
  logic [PW-1:0]         w_a_ext;
  logic [PW-1:0]         w_b_ext;
  logic [PW-1:0]         w_prod;
  logic [ACC_WIDTH:0]    w_p_wide;
  logic [ACC_WIDTH:0]    w_acc_wide;
  logic [ACC_WIDTH:0]    w_sum;
  logic                  w_sum_ovf;
  logic [ACC_WIDTH-1:0]  w_sat;
  logic                  w_restart;

  // The low PW bits of the product of PW-bit extended operands equal the true
  // signed/unsigned product, so one multiplier serves both modes.
  assign w_a_sx     = (SIGNED != 0) & a_in[DATA_WIDTH-1];
  assign w_b_sx     = (SIGNED != 0) & b_in[DATA_WIDTH-1];
  assign w_a_ext    = {{DATA_WIDTH{w_a_sx}}, a_in};
  assign w_b_ext    = {{DATA_WIDTH{w_b_sx}}, b_in};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_p_sx     = (SIGNED != 0) & w_prod[PW-1];
  assign w_p_wide   = {{(ACC_WIDTH + 1 - PW){w_p_sx}}, w_prod};
  assign w_acc_wide = {(SIGNED != 0) & r_acc[ACC_WIDTH-1], r_acc};
  assign w_sum      = w_acc_wide + w_p_wide;
  assign w_sum_ovf  = (SIGNED != 0) ? (w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1]) : w_sum[ACC_WIDTH];
  assign w_restart  = drain | acc_clear;

  always_comb begin
    if (SIGNED != 0)
      w_sat = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      w_sat = {ACC_WIDTH{1'b1}};
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_acc_nxt = r_acc;
    w_ovf_nxt = overflow;
    if (w_restart) begin
      w_acc_nxt = in_valid ? w_p_wide[ACC_WIDTH-1:0] : '0;
      if (acc_clear && !drain) w_ovf_nxt = 1'b0;
    end else if (in_valid) begin
      w_acc_nxt = w_sum[ACC_WIDTH-1:0];
      if (w_sum_ovf) begin
        w_ovf_nxt = 1'b1;
        if (SATURATE != 0) w_acc_nxt = w_sat;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc    <= '0;
      overflow <= 1'b0;
    end else begin
      r_acc    <= w_acc_nxt;
      overflow <= w_ovf_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_restart) w_state_nxt = in_valid ? S_ACCUM : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_ACCUM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out     <= '0;
      b_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        a_out <= a_in;
        b_out <= b_in;
      end
    end
  end

  // A local drain overrides the chain shift; a held, unshifted result being replaced is an overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_out       <= '0;
      c_out_valid <= 1'b0;
      overrun     <= 1'b0;
    end else if (drain) begin
      c_out       <= r_acc;
      c_out_valid <= 1'b1;
      if (c_out_valid && !c_shift) overrun <= 1'b1;
    end else if (c_shift) begin
      c_out       <= c_in;
      c_out_valid <= c_in_valid;
    end
  end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed bench for systolic_mac_pe: four instances share one stimulus stream and differ only in
// SIGNED / ACC_WIDTH / SATURATE; each sequence checks the instance it targets.
module tb_systolic_mac_pe;

  logic        clk;
  logic        rst;
  logic [15:0] a_in, b_in;
  logic        in_valid, acc_clear, drain, c_in_valid, c_shift;
  logic [39:0] c_in;

  logic [15:0] a_out0, b_out0, a_out1, b_out1, a_out2, b_out2, a_out3, b_out3;
  logic        ov0, ov1, ov2, ov3, cov0, cov1, cov2, cov3;
  logic        busy0, busy1, busy2, busy3, ovf0, ovf1, ovf2, ovf3, ovr0, ovr1, ovr2, ovr3;
  logic [39:0] c_out0, c_out1;
  logic [31:0] c_out2, c_out3;

  int n_checks = 0;
  int n_fail   = 0;

  systolic_mac_pe #(.DATA_WIDTH(16), .ACC_WIDTH(40), .SIGNED(1), .SATURATE(1)) dut0 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .acc_clear(acc_clear),
    .drain(drain), .c_in(c_in), .c_in_valid(c_in_valid), .c_shift(c_shift),
    .a_out(a_out0), .b_out(b_out0), .out_valid(ov0), .c_out(c_out0), .c_out_valid(cov0),
    .busy(busy0), .overflow(ovf0), .overrun(ovr0));

  systolic_mac_pe #(.DATA_WIDTH(16), .ACC_WIDTH(40), .SIGNED(0), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .acc_clear(acc_clear),
    .drain(drain), .c_in(c_in), .c_in_valid(c_in_valid), .c_shift(c_shift),
    .a_out(a_out1), .b_out(b_out1), .out_valid(ov1), .c_out(c_out1), .c_out_valid(cov1),
    .busy(busy1), .overflow(ovf1), .overrun(ovr1));

  systolic_mac_pe #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SIGNED(1), .SATURATE(1)) dut2 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .acc_clear(acc_clear),
    .drain(drain), .c_in(c_in[31:0]), .c_in_valid(c_in_valid), .c_shift(c_shift),
    .a_out(a_out2), .b_out(b_out2), .out_valid(ov2), .c_out(c_out2), .c_out_valid(cov2),
    .busy(busy2), .overflow(ovf2), .overrun(ovr2));

  systolic_mac_pe #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SIGNED(1), .SATURATE(0)) dut3 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .acc_clear(acc_clear),
    .drain(drain), .c_in(c_in[31:0]), .c_in_valid(c_in_valid), .c_shift(c_shift),
    .a_out(a_out3), .b_out(b_out3), .out_valid(ov3), .c_out(c_out3), .c_out_valid(cov3),
    .busy(busy3), .overflow(ovf3), .overrun(ovr3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        v, clr, drn, csh, civ;
    logic [39:0] cin;
    logic [15:0] ao, bo;
    logic        ov;
    logic [39:0] co;
    logic        cov, busy, ovr;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic v, input logic clr,
                       input logic drn, input logic csh, input logic civ, input logic [39:0] cin);
    @(negedge clk);
    a_in = a; b_in = b; in_valid = v; acc_clear = clr; drain = drn;
    c_shift = csh; c_in_valid = civ; c_in = cin;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_in = '0; b_in = '0; in_valid = 1'b0; acc_clear = 1'b0; drain = 1'b0;
    c_shift = 1'b0; c_in_valid = 1'b0; c_in = '0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " a_out"}, 64'(a_out0), 64'd0);
    check({tag, " b_out"}, 64'(b_out0), 64'd0);
    check({tag, " out_valid"}, 64'(ov0), 64'd0);
    check({tag, " c_out"}, 64'(c_out0), 64'd0);
    check({tag, " c_out_valid"}, 64'(cov0), 64'd0);
    check({tag, " busy"}, 64'(busy0), 64'd0);
    check({tag, " overflow"}, 64'(ovf0), 64'd0);
    check({tag, " overrun"}, 64'(ovr0), 64'd0);
  endtask

  initial begin
    // a, b, v, clr, drn, csh, civ, cin | a_out, b_out, out_valid, c_out, c_out_valid, busy, overrun
    tbl[0]  = '{16'd3, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0,  16'd3, 16'd5, 1'b1, 40'h0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{16'd2, 16'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 40'h0,  16'd2, 16'd3, 1'b1, 40'h0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{16'd0, 16'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0,  16'd0, 16'd7, 1'b1, 40'h0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{16'd4, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0,  16'd4, 16'd0, 1'b1, 40'h0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{16'hFFFE, 16'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0, 16'hFFFE, 16'd6, 1'b1, 40'h0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'h0,  16'hFFFE, 16'd6, 1'b0, 40'hFF_FFFF_FFFA, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{16'd1, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0,  16'd1, 16'd1, 1'b1, 40'hFF_FFFF_FFFA, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{16'd1, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0,  16'd1, 16'd1, 1'b1, 40'hFF_FFFF_FFFA, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{16'd4, 16'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 40'h11, 16'd4, 16'd4, 1'b1, 40'd2, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 40'h55, 16'd4, 16'd4, 1'b0, 40'h55, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 40'h77, 16'd4, 16'd4, 1'b0, 40'd16, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{16'd5, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0,  16'd5, 16'd5, 1'b1, 40'd16, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'h0,  16'd5, 16'd5, 1'b0, 40'd25, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'h0,  16'd5, 16'd5, 1'b0, 40'd0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 40'h99, 16'd5, 16'd5, 1'b0, 40'h99, 1'b0, 1'b0, 1'b1};

    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].a, tbl[i].b, tbl[i].v, tbl[i].clr, tbl[i].drn, tbl[i].csh, tbl[i].civ, tbl[i].cin);
      check($sformatf("row%0d a_out", i), 64'(a_out0), 64'(tbl[i].ao));
      check($sformatf("row%0d b_out", i), 64'(b_out0), 64'(tbl[i].bo));
      check($sformatf("row%0d out_valid", i), 64'(ov0), 64'(tbl[i].ov));
      check($sformatf("row%0d c_out", i), 64'(c_out0), 64'(tbl[i].co));
      check($sformatf("row%0d c_out_valid", i), 64'(cov0), 64'(tbl[i].cov));
      check($sformatf("row%0d busy", i), 64'(busy0), 64'(tbl[i].busy));
      check($sformatf("row%0d overrun", i), 64'(ovr0), 64'(tbl[i].ovr));
    end

    // Asynchronous reset in the middle of a tile, between clock edges.
    apply(16'd7, 16'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0);
    check("midtile busy", 64'(busy0), 64'd1);
    check("midtile overrun held", 64'(ovr0), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    apply(16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'h0);
    check("post_rst drain c_out", 64'(c_out0), 64'd0);
    check("post_rst drain c_out_valid", 64'(cov0), 64'd1);
    check("post_rst drain overrun", 64'(ovr0), 64'd0);

    // Unsigned full-scale product versus the same bits read as signed (-1 * -1).
    reset_pulse();
    apply(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 40'h0);
    apply(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'h0);
    check("unsigned c_out", 64'(c_out1), 64'hFFFE0001);
    check("unsigned c_out_valid", 64'(cov1), 64'd1);
    check("unsigned busy", 64'(busy1), 64'd0);
    check("unsigned overflow", 64'(ovf1), 64'd0);
    check("signed -1*-1 c_out", 64'(c_out0), 64'd1);

    // Saturation vs wrap on a 32-bit accumulator; the 40-bit instance has headroom.
    reset_pulse();
    apply(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0);
    apply(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0);
    check("sat 2nd add overflow", 64'(ovf2), 64'd0);
    apply(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0);
    check("sat overflow", 64'(ovf2), 64'd1);
    check("wrap overflow", 64'(ovf3), 64'd1);
    check("wide no overflow", 64'(ovf0), 64'd0);
    apply(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40'h0);
    check("sat c_out", 64'(c_out2), 64'h7FFFFFFF);
    check("wrap c_out", 64'(c_out3), 64'hBFFD0003);
    check("wide c_out", 64'(c_out0), 64'hBFFD0003);
    check("sat overflow after drain", 64'(ovf2), 64'd1);
    apply(16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 40'h0);
    check("sat overflow after clear", 64'(ovf2), 64'd0);
    check("wrap overflow after clear", 64'(ovf3), 64'd0);
    check("sat busy after clear", 64'(busy2), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_mac_pe.md
Name: systolic_mac_pe

Overview:
Parametrised output-stationary processing element for the systolic matrix-multiply array.
- Each cycle with valid data it multiplies the west/north operands, accumulates into a wide accumulator and forwards the operands east/south with one cycle of latency.
- A drain command moves the finished result into a double-buffered result register that shifts along a column result chain, so the next tile can start accumulating immediately.
- Supports signed or unsigned operands, optional saturation and sticky overflow/overrun flags.

Parameters:
- DATA_WIDTH, 16, operand width of a_in/b_in.
- ACC_WIDTH, 40, accumulator and result width; must be >= 2*DATA_WIDTH.
- SIGNED, 1, 1 = two's-complement operands and accumulator; 0 = unsigned.
- SATURATE, 1, 1 = clamp the accumulator on overflow; 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- a_in  in  DATA_WIDTH  west operand.
- b_in  in  DATA_WIDTH  north operand.
- in_valid  in  1  a_in/b_in carry a real operand pair this cycle.
- acc_clear  in  1  start a new tile; discard the accumulator.
- drain  in  1  transfer the accumulator to the result register.
- c_in  in  ACC_WIDTH  result from the upstream PE in the chain.
- c_in_valid  in  1  c_in carries a result.
- c_shift  in  1  chain shift enable (column-global).
- a_out  out  DATA_WIDTH  registered a_in to the east neighbour.
- b_out  out  DATA_WIDTH  registered b_in to the south neighbour.
- out_valid  out  1  registered in_valid.
- c_out  out  ACC_WIDTH  result register.
- c_out_valid  out  1  c_out holds a result.
- busy  out  1  state == ACCUM.
- overflow  out  1  sticky; the accumulator saturated or wrapped.
- overrun  out  1  sticky; an unshifted result was overwritten.

Behaviour:
- Reset (rst=0, asynchronous): all outputs, the accumulator and the FSM go to 0/IDLE immediately. Release of reset is synchronous to clk. Reset mid-tile discards all data.
- Operand pipe:
  - in_valid=1: a_out<=a_in, b_out<=b_in, out_valid<=1.
  - in_valid=0: a_out/b_out hold their values, out_valid<=0.
  - Latency is exactly 1 cycle.
  - Zero operands are ordinary data; only in_valid gates accumulation.
- Product: p = a_in*b_in at 2*DATA_WIDTH bits, then sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_WIDTH. The sum is computed at ACC_WIDTH+1 bits to detect overflow.
- Accumulator update, in priority order:
  1. drain or acc_clear: acc <= in_valid ? p : 0. The product of that same cycle belongs to the new tile.
  2. Otherwise, in_valid: acc <= acc + p.
  3. Otherwise: acc holds.
- Overflow: if the sum leaves the ACC_WIDTH range, overflow<=1.
  - SATURATE=1: acc is clamped to the max/min representable value.
  - SATURATE=0: acc keeps the truncated sum.
  - acc_clear also clears overflow. drain does not clear it.
- FSM:
  - IDLE -> ACCUM on any accepted in_valid.
  - ACCUM -> IDLE on drain or acc_clear without in_valid.
  - ACCUM -> ACCUM on drain or acc_clear with in_valid.
  - busy = (state == ACCUM).
- Result register, in priority order:
  1. drain: c_out <= acc (the pre-update value), c_out_valid<=1. drain in IDLE drains 0 with c_out_valid=1. If c_out_valid=1 and c_shift=0 in that cycle, overrun<=1.
  2. Otherwise, c_shift: c_out<=c_in, c_out_valid<=c_in_valid.
  3. Otherwise: hold.
- drain and c_shift in the same cycle: drain wins; c_in is dropped; overrun is not set.
- overrun is cleared only by reset.
- acc_clear and drain together: behaves as drain.

Test Plan:
1. Reset and pipe: DATA_WIDTH=16, rst pulsed low mid-tile -> all outputs 0 asynchronously. Then in_valid=1, a_in=3, b_in=5 -> next cycle a_out=3, b_out=5, out_valid=1.
2. Dot product with zeros: pairs (2,3), (0,7), (4,0), (-2,6) with SIGNED=1, then drain -> c_out=-6, c_out_valid=1, busy=0. Repeat with SIGNED=0 and 0xFFFF*0xFFFF once -> c_out=0xFFFE0001.
3. Back-to-back tiles: tile 1 = 1*1, 1*1; drain asserted in the same cycle as the first pair of tile 2 (4*4) -> c_out=2, acc=16, busy stays 1.
4. Saturation: ACC_WIDTH=32, SIGNED=1, accumulate 32767*32767 three times -> acc=0x7FFFFFFF, overflow=1. acc_clear -> overflow=0. With SATURATE=0, same stimulus -> wrapped sum, overflow=1.
5. Chain and overrun:
   - c_shift with c_in=0x55, c_in_valid=1 -> c_out=0x55.
   - drain and c_shift together -> local result wins.
   - Two drains with no shift -> overrun=1, c_out = second result.
